// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] fixed
);

    // Add 3 so the following left shift carries into the next decimal digit.
    always_comb begin
        fixed = (digit >= 4'd5) ? (digit + 4'd3) : digit;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock)
// with valid/ready handshakes on both sides and saturation on overflow.
// Optional leading-zero mask output blank_o when BCD_BLANK_EN is defined.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          valid_i,
    input  logic [IN_W-1:0]               bin_i,
    output logic                          ready_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
    output logic                          overflow_o
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]             blank_o
`endif
);

    localparam int unsigned ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_W + 1);

    state_t            state;
    state_t            state_nxt;
    logic [IN_W-1:0]   shreg;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_fix;
    logic [ACC_W-1:0]  acc_shift;
    logic [ACC_W-1:0]  bcd_final;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              ovf_shift;
    logic              accept;
    logic              last;

    // Per-digit add-3 correction, no carry between digits.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_add3 u_add3 (
            .digit(acc[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .fixed(acc_fix[BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    // Next accumulator after one shift; the bit leaving the top digit marks overflow.
    always_comb begin
        acc_shift = {acc_fix[ACC_W-2:0], shreg[IN_W-1]};
        ovf_shift = ovf | acc_fix[ACC_W-1];
        bcd_final = ovf_shift ? {DIGITS{BCD_NINE}} : acc_shift;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        valid_o   = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Working registers: load on accept, shift one bit per SHIFT cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            shreg <= bin_i;
            acc   <= '0;
            cnt   <= CNT_W'(IN_W);
            ovf   <= 1'b0;
        end else if (state == SHIFT) begin
            shreg <= shreg << 1;
            acc   <= acc_shift;
            cnt   <= cnt - 1'b1;
            ovf   <= ovf_shift;
        end
    end

    // Result registers capture the final shift directly so they are ready with valid_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bcd_o      <= '0;
            overflow_o <= 1'b0;
        end else if (last) begin
            bcd_o      <= bcd_final;
            overflow_o <= ovf_shift;
        end
    end

`ifdef BCD_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    logic [DIGITS-1:0] blank_nxt;
    logic              zero_above;
    int unsigned       idx;

    // Digit k is blanked when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        idx        = 0;
        for (int unsigned j = 1; j < DIGITS; j++) begin
            idx            = DIGITS - j;
            zero_above     = zero_above & (bcd_final[BCD_DIGIT_W*idx +: BCD_DIGIT_W] == '0);
            blank_nxt[idx] = zero_above;
        end
    end

    // Mask register updates together with bcd_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blank_o <= BLANK_RST;
        end else if (last) begin
            blank_o <= blank_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: three configurations (8/3, 8/2, 16/5).
module tb_bin_to_bcd_seq;

    typedef struct {
        int          sel;
        int unsigned val;
        logic [19:0] bcd;
        logic        ovf;
        logic [4:0]  blank;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy_in = 1'b1;
    logic        va = 1'b0, vb = 1'b0, vc = 1'b0;
    logic [7:0]  bina = '0, binb = '0;
    logic [15:0] binc = '0;
    logic        rdy_a, rdy_b, rdy_c, vo_a, vo_b, vo_c, ovf_a, ovf_b, ovf_c;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;
    logic [19:0] bcd_c;
`ifdef BCD_BLANK_EN
    logic [2:0]  blank_a;
    logic [1:0]  blank_b;
    logic [4:0]  blank_c;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bin_to_bcd_seq #(.IN_W(8), .DIGITS(3)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(va), .bin_i(bina), .ready_o(rdy_a),
        .valid_o(vo_a), .ready_i(rdy_in), .bcd_o(bcd_a), .overflow_o(ovf_a)
`ifdef BCD_BLANK_EN
        , .blank_o(blank_a)
`endif
    );

    bin_to_bcd_seq #(.IN_W(8), .DIGITS(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vb), .bin_i(binb), .ready_o(rdy_b),
        .valid_o(vo_b), .ready_i(rdy_in), .bcd_o(bcd_b), .overflow_o(ovf_b)
`ifdef BCD_BLANK_EN
        , .blank_o(blank_b)
`endif
    );

    bin_to_bcd_seq #(.IN_W(16), .DIGITS(5)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vc), .bin_i(binc), .ready_o(rdy_c),
        .valid_o(vo_c), .ready_i(rdy_in), .bcd_o(bcd_c), .overflow_o(ovf_c)
`ifdef BCD_BLANK_EN
        , .blank_o(blank_c)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int digits_of(input int sel);
        return (sel == 0) ? 3 : (sel == 1) ? 2 : 5;
    endfunction

    function automatic int lat_of(input int sel);
        return (sel == 2) ? 16 : 8;
    endfunction

    function automatic logic out_valid(input int sel);
        return (sel == 0) ? vo_a : (sel == 1) ? vo_b : vo_c;
    endfunction

    function automatic logic out_ready(input int sel);
        return (sel == 0) ? rdy_a : (sel == 1) ? rdy_b : rdy_c;
    endfunction

    // Reference: decimal digits by division, saturating at 10^digits - 1.
    function automatic void ref_conv(input int unsigned digits, input int unsigned val,
                                     output logic [19:0] bcd, output logic ovf,
                                     output logic [4:0] blank);
        int unsigned lim = 1;
        int unsigned v;
        int unsigned p = 1;
        for (int i = 0; i < int'(digits); i++) lim = lim * 10;
        ovf   = (val >= lim);
        v     = ovf ? lim - 1 : val;
        bcd   = '0;
        blank = '0;
        for (int i = 0; i < int'(digits); i++) begin
            bcd[4*i +: 4] = 4'((v / p) % 10);
            if (i >= 1 && v < p) blank[i] = 1'b1;
            p = p * 10;
        end
    endfunction

    // Called at a negedge with the selected DUT idle; returns at a negedge.
    task automatic convert(input int sel, input int unsigned val,
                           output logic [19:0] bcd, output logic ovf, output logic [4:0] blank,
                           output int lat, output logic one_cycle, output int acc_cyc);
        acc_cyc = cyc;
        case (sel)
            0: begin va = 1'b1; bina = val[7:0]; end
            1: begin vb = 1'b1; binb = val[7:0]; end
            default: begin vc = 1'b1; binc = val[15:0]; end
        endcase
        @(negedge clk);
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        lat = 0;
        while (!out_valid(sel) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        blank = '0;
        case (sel)
            0: begin bcd = {8'h0, bcd_a}; ovf = ovf_a; end
            1: begin bcd = {12'h0, bcd_b}; ovf = ovf_b; end
            default: begin bcd = bcd_c; ovf = ovf_c; end
        endcase
`ifdef BCD_BLANK_EN
        case (sel)
            0: blank = {2'b0, blank_a};
            1: blank = {3'b0, blank_b};
            default: blank = blank_c;
        endcase
`endif
        @(negedge clk);
        one_cycle = !out_valid(sel) && out_ready(sel);
    endtask

    initial begin
        vec_t        tbl[12];
        logic [19:0] bcd, e_bcd;
        logic        ovf, e_ovf, one;
        logic [4:0]  blank, e_blank;
        int          lat, acc0, acc1, bad, sel;
        int unsigned val;

        tbl[0]  = '{0, 255,   20'h00255, 1'b0, 5'b00000};
        tbl[1]  = '{0, 0,     20'h00000, 1'b0, 5'b00110};
        tbl[2]  = '{0, 9,     20'h00009, 1'b0, 5'b00110};
        tbl[3]  = '{0, 10,    20'h00010, 1'b0, 5'b00100};
        tbl[4]  = '{0, 100,   20'h00100, 1'b0, 5'b00000};
        tbl[5]  = '{1, 99,    20'h00099, 1'b0, 5'b00000};
        tbl[6]  = '{1, 100,   20'h00099, 1'b1, 5'b00000};
        tbl[7]  = '{1, 0,     20'h00000, 1'b0, 5'b00010};
        tbl[8]  = '{1, 255,   20'h00099, 1'b1, 5'b00000};
        tbl[9]  = '{2, 65535, 20'h65535, 1'b0, 5'b00000};
        tbl[10] = '{2, 10000, 20'h10000, 1'b0, 5'b00000};
        tbl[11] = '{2, 0,     20'h00000, 1'b0, 5'b11110};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_a", {29'h0, rdy_a, vo_a, ovf_a}, 32'h4);
        chk("rst_a_bcd", {20'h0, bcd_a}, 32'h0);
        chk("rst_b", {21'h0, rdy_b, vo_b, ovf_b, bcd_b}, {21'h0, 3'b100, 8'h00});
        chk("rst_c", {9'h0, rdy_c, vo_c, ovf_c, bcd_c}, {9'h0, 3'b100, 20'h0});
`ifdef BCD_BLANK_EN
        chk("rst_blank", {22'h0, blank_c, blank_b, blank_a}, {22'h0, 5'b11110, 2'b10, 3'b110});
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            convert(tbl[i].sel, tbl[i].val, bcd, ovf, blank, lat, one, acc0);
            chk($sformatf("vec%0d_bcd", i), {12'h0, bcd}, {12'h0, tbl[i].bcd});
            chk($sformatf("vec%0d_ovf", i), {31'h0, ovf}, {31'h0, tbl[i].ovf});
            chk($sformatf("vec%0d_lat", i), lat, lat_of(tbl[i].sel));
            chk($sformatf("vec%0d_onecycle", i), {31'h0, one}, 32'h1);
`ifdef BCD_BLANK_EN
            chk($sformatf("vec%0d_blank", i), {27'h0, blank}, {27'h0, tbl[i].blank});
`endif
        end

        // Randomized against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 2));
            val = (sel == 2) ? $urandom_range(0, 65535) : $urandom_range(0, 255);
            ref_conv(digits_of(sel), val, e_bcd, e_ovf, e_blank);
            convert(sel, val, bcd, ovf, blank, lat, one, acc0);
            chk($sformatf("rnd%0d_bcd", i), {12'h0, bcd}, {12'h0, e_bcd});
            chk($sformatf("rnd%0d_ovf", i), {31'h0, ovf}, {31'h0, e_ovf});
            chk($sformatf("rnd%0d_lat", i), lat, lat_of(sel));
`ifdef BCD_BLANK_EN
            chk($sformatf("rnd%0d_blank", i), {27'h0, blank}, {27'h0, e_blank});
`endif
        end

        // Back-to-back: 0 then 128
        convert(0, 0, bcd, ovf, blank, lat, one, acc0);
        chk("b2b_first", {12'h0, bcd}, 32'h0);
`ifdef BCD_BLANK_EN
        chk("b2b_first_blank", {27'h0, blank}, 32'h6);
`endif
        convert(0, 128, bcd, ovf, blank, lat, one, acc1);
        chk("b2b_second", {12'h0, bcd}, 32'h128);
        chk("b2b_gap", acc1 - acc0, 10);
`ifdef BCD_BLANK_EN
        chk("b2b_second_blank", {27'h0, blank}, 32'h0);
`endif

        // Back-pressure: hold result 20 cycles, ignore a valid_i pulse
        rdy_in = 1'b0;
        va = 1'b1; bina = 8'd42;
        @(negedge clk);
        va = 1'b0;
        lat = 0;
        while (!vo_a && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_lat", lat, 8);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!(vo_a === 1'b1 && bcd_a === 12'h042 && rdy_a === 1'b0 && ovf_a === 1'b0)) bad++;
            if (i == 5) begin va = 1'b1; bina = 8'd7; end
            if (i == 6) va = 1'b0;
            @(negedge clk);
        end
        chk("bp_hold_bad_cycles", bad, 0);
        rdy_in = 1'b1;
        @(negedge clk);
        chk("bp_release", {29'h0, vo_a, rdy_a, 1'b0}, 32'h2);
        chk("bp_bcd_held_idle", {20'h0, bcd_a}, 32'h042);
        repeat (3) @(negedge clk);
        chk("bp_pulse_ignored", {30'h0, vo_a, rdy_a}, 32'h1);

        // Reset in the middle of a conversion of 200
        va = 1'b1; bina = 8'd200;
        @(negedge clk);
        va = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_hs", {29'h0, rdy_a, vo_a, ovf_a}, 32'h4);
        chk("midrst_bcd", {20'h0, bcd_a}, 32'h0);
`ifdef BCD_BLANK_EN
        chk("midrst_blank", {29'h0, blank_a}, 32'h6);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        convert(0, 7, bcd, ovf, blank, lat, one, acc0);
        chk("midrst_next_bcd", {12'h0, bcd}, 32'h007);
        chk("midrst_next_ovf", {31'h0, ovf}, 32'h0);
        chk("midrst_next_lat", lat, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential, parametrised binary-to-BCD converter for the scoreboard datapath. It is the next generation of the single-cycle two-digit divider. It converts an IN_W-bit unsigned value into DIGITS packed BCD digits using iterative shift-and-add-3 (double dabble), one input bit per clock. It uses a valid/ready handshake on both sides, saturates on overflow, and can optionally emit leading-zero blanking for the 7-segment driver.

## Interface
- IN_W, default 8: binary input width; legal range ≥1.
- DIGITS, default 3: number of BCD output digits; legal range ≥1.
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input value present.
- bin_i  in  IN_W  unsigned binary input.
- ready_o  out  1  converter can accept input.
- valid_o  out  1  result available.
- ready_i  in  1  downstream accepts result.
- bcd_o  out  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k]; digit 0 is the ones digit.
- overflow_o  out  1  bin_i was ≥10^DIGITS; bcd_o is saturated.
- blank_o  out  DIGITS  leading-zero mask (only present with BCD_BLANK_EN).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o: latch bin_i into the shift register, clear the BCD accumulator and overflow flag, set bit counter=IN_W, go to SHIFT.
- SHIFT, one input bit per cycle:
  - Each digit ≥5 gets +3.
  - Then {accumulator, shift reg} shifts left by 1; the MSB of bin enters digit 0.
  - The bit shifted out of the top digit ORs into the sticky overflow flag.
  - The counter decrements. When the counter reaches 1 on this edge, go to DONE.
- DONE:
  - valid_o=1. bcd_o and overflow_o are stable.
  - On ready_i: go to IDLE.
  - A new input is not accepted in the same cycle; ready_o=0 in DONE.
- Output registers:
  - bcd_o and overflow_o load only on the SHIFT→DONE edge.
  - They hold their value in IDLE until the next result.
  - If overflow is set, bcd_o is loaded with all digits = 9.
- Arithmetic:
  - The accumulator is 4*DIGITS bits.
  - Add-3 correction is per 4-bit digit, with no carry between digits.
- valid_i and bin_i are ignored in SHIFT and DONE.

## Timing
- Reset values:
  - state=IDLE, ready_o=1, valid_o=0.
  - bcd_o=0, overflow_o=0.
  - blank_o = all ones except bit 0.
- Latency: valid_o rises exactly IN_W clock edges after the accepting edge. IN_W=8 gives 8 cycles.
- Minimum throughput: one conversion per IN_W+2 cycles (accept edge, IN_W shifts, and one DONE cycle with ready_i=1).
- Back-pressure: valid_o, bcd_o and overflow_o hold indefinitely while ready_i=0.
- Reset mid-conversion: rst_ni low immediately forces all reset values, and the partial result is discarded.
- IN_W=1: a single SHIFT cycle.

## Configuration
- BCD_BLANK_EN defined:
  - blank_o is a registered output, updated together with bcd_o.
  - blank_o[k]=1 when digit k and all higher digits are 0, for k≥1.
  - blank_o[0] is always 0, so value 0 displays a single "0".
- BCD_BLANK_EN undefined:
  - The blank_o port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package bcd_pkg holds:
  - BCD_DIGIT_W=4.
  - The state enum typedef (IDLE, SHIFT, DONE).
  - The constant BCD_NINE=4'd9.
- Sub-module bcd_add3:
  - 4-bit combinational digit correction (in≥5 ? in+3 : in).
  - Instantiated DIGITS times with a generate loop.
- The counter width is $clog2(IN_W+1).

## Test plan
- IN_W=8, DIGITS=3, bin_i=255 → after 8 cycles, bcd_o=0x255, overflow_o=0, valid_o=1 for exactly 1 cycle with ready_i=1.
- IN_W=8, DIGITS=2:
  - bin_i=99 → bcd_o=0x99, overflow_o=0.
  - bin_i=100 → bcd_o=0x99, overflow_o=1.
- Back-pressure: bin_i=42, ready_i=0 for 20 cycles.
  - Required: valid_o stays 1, bcd_o=0x042, ready_o=0, and a valid_i pulse during that time is ignored.
  - After ready_i=1: IDLE, ready_o=1.
- Reset mid-conversion: accept 200, pull rst_ni low at cycle 4.
  - Required: immediately ready_o=1, valid_o=0, bcd_o=0.
  - A subsequent conversion of 7 yields 0x007.
- Back-to-back: convert 0 then 128.
  - Required: results 0x000 then 0x128.
  - Second accept no earlier than 10 cycles after the first.
  - With BCD_BLANK_EN: blank_o=3'b110 then 3'b000.
- IN_W=16, DIGITS=5, bin_i=65535 → bcd_o=0x65535, overflow_o=0, latency 16.
